// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg: shared constants and requester encoding for the register write-back path
package gpr_wb_arbiter_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {WB_EXU = 1'b0, WB_LSU = 1'b1} wb_req_e;
endpackage

// File: rtl/wb_rr_arb2.sv
// wb_rr_arb2: two-input round-robin arbiter holding the priority bit
import gpr_wb_arbiter_pkg::*;
module wb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_req_e prio_q, prio_d;
  // grant the lone requester, or the prioritised one on contention; hand priority over after a grant
  always_comb begin
    gnt[WB_EXU] = req[WB_EXU] && (!req[WB_LSU] || prio_q == WB_EXU);
    gnt[WB_LSU] = req[WB_LSU] && (!req[WB_EXU] || prio_q == WB_LSU);
    prio_d = gnt[WB_EXU] ? WB_LSU : gnt[WB_LSU] ? WB_EXU : prio_q;
  end
  // priority register, starts at LSU
  always_ff @(posedge clk or negedge rst)
    if (!rst) prio_q <= WB_LSU;
    else prio_q <= prio_d;
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the GPR write port between EXU and LSU and tracks pending writes per register
`ifndef XLEN
`define XLEN 32
`endif
import gpr_wb_arbiter_pkg::*;
module gpr_wb_arbiter #(
  parameter int XLEN = `XLEN,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  exu_valid,
  input  logic [REG_ADDR_W-1:0] exu_rd,
  input  logic [XLEN-1:0]       exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  output logic                  rd_wen,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       x_rd,
  output logic                  sb_empty
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0] req, gnt;
  logic [CNT_W-1:0] cnt_q [REG_NUM];
  logic [CNT_W-1:0] cnt_d [REG_NUM];
  logic iss, com;
  // requests are withheld during flush and while reset is asserted, so nothing is accepted then
  assign req = {lsu_valid && rst && !flush, exu_valid && rst && !flush};
  wb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );
  // ready equals grant; the write port carries the granted requester, zero when idle
  always_comb begin
    exu_ready = gnt[WB_EXU];
    lsu_ready = gnt[WB_LSU];
    rd = gnt[WB_EXU] ? exu_rd : gnt[WB_LSU] ? lsu_rd : '0;
    x_rd = gnt[WB_EXU] ? exu_data : gnt[WB_LSU] ? lsu_data : '0;
    rd_wen = |gnt && rd != '0;
  end
  // pending-write counters: issue increments, commit decrements, both to one register cancel out
  always_comb begin
    issue_ready = !(issue_rd != '0 && cnt_q[issue_rd] == CNT_MAX);
    iss = issue_valid && issue_ready && issue_rd != '0 && !flush;
    com = rd_wen;
    rs1_busy = cnt_q[rs1] != '0;
    rs2_busy = cnt_q[rs2] != '0;
    sb_empty = 1'b1;
    for (int i = 0; i < REG_NUM; i++) begin
      sb_empty &= cnt_q[i] == '0;
      cnt_d[i] = (flush || i == 0) ? '0 :
                 (iss && issue_rd == REG_ADDR_W'(i) && !(com && rd == REG_ADDR_W'(i))) ? cnt_q[i] + CNT_W'(1) :
                 (com && rd == REG_ADDR_W'(i) && !(iss && issue_rd == REG_ADDR_W'(i)) && cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) :
                 cnt_q[i];
    end
  end
  // scoreboard state, cleared on reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed and randomized checks against a behavioural scoreboard/arbiter model
module tb_gpr_wb_arbiter;
  localparam int MAXC = 3;
  logic clk = 0;
  logic rst, flush, issue_valid, exu_valid, lsu_valid;
  logic [4:0] issue_rd, rs1, rs2, exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_data;
  logic issue_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready, rd_wen, sb_empty;
  logic [4:0] rd;
  logic [31:0] x_rd;
  int ncmp = 0, nfail = 0;
  int cnt [32];
  bit prio_lsu;
  bit m_ge, m_gl;
  logic [4:0] m_rd;
  bit m_iss_rdy;

  gpr_wb_arbiter #(.XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rd_wen(rd_wen), .rd(rd), .x_rd(x_rd), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (cnt[i]) cnt[i] = 0;
    prio_lsu = 1;
  endtask

  // checks all outputs against the model, then advances the model across one rising edge
  task automatic cycle();
    bit live, empty, iss, com;
    logic [31:0] ed;
    #1;
    if (!rst) model_reset();
    live = rst && !flush;
    m_ge = live && exu_valid && (!lsu_valid || !prio_lsu);
    m_gl = live && lsu_valid && (!exu_valid || prio_lsu);
    m_rd = m_ge ? exu_rd : m_gl ? lsu_rd : 5'd0;
    ed = m_ge ? exu_data : m_gl ? lsu_data : 32'd0;
    m_iss_rdy = !(issue_rd != 0 && cnt[issue_rd] == MAXC);
    empty = 1;
    foreach (cnt[i]) if (cnt[i] != 0) empty = 0;
    chk("exu_ready", exu_ready, m_ge);
    chk("lsu_ready", lsu_ready, m_gl);
    chk("rd", rd, m_rd);
    chk("x_rd", x_rd, ed);
    chk("rd_wen", rd_wen, (m_ge || m_gl) && m_rd != 0);
    chk("issue_ready", issue_ready, m_iss_rdy);
    chk("rs1_busy", rs1_busy, cnt[rs1] != 0);
    chk("rs2_busy", rs2_busy, cnt[rs2] != 0);
    chk("sb_empty", sb_empty, empty);
    @(posedge clk);
    if (!rst) model_reset();
    else if (flush) foreach (cnt[i]) cnt[i] = 0;
    else begin
      iss = issue_valid && m_iss_rdy && issue_rd != 0;
      com = (m_ge || m_gl) && m_rd != 0;
      if (!(iss && com && issue_rd == m_rd)) begin
        if (iss) cnt[issue_rd]++;
        if (com && cnt[m_rd] > 0) cnt[m_rd]--;
      end
      if (m_ge) prio_lsu = 1;
      if (m_gl) prio_lsu = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 0; flush = 0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    exu_valid = 1; exu_rd = 1; exu_data = 32'h11; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    @(negedge clk);
    #1;
    chk("rst_rd_wen", rd_wen, 0);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_issue_ready", issue_ready, 1);
    cycle();
    cycle();
    rst = 1;
    #1;
    chk("rel_exu_ready", exu_ready, 1);
    chk("rel_rd_wen", rd_wen, 1);
    cycle();
    exu_rd = 5; exu_data = 32'hA; lsu_valid = 1; lsu_rd = 6; lsu_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_rd", rd, (k % 2 == 0) ? 5'd6 : 5'd5);
      chk("cont_x_rd", x_rd, (k % 2 == 0) ? 32'hB : 32'hA);
      chk("cont_lsu_ready", lsu_ready, k % 2 == 0);
      cycle();
    end
    lsu_valid = 0; exu_rd = 0; exu_data = 32'hFF;
    #1;
    chk("x0_exu_ready", exu_ready, 1);
    chk("x0_rd_wen", rd_wen, 0);
    cycle();
    chk("x0_sb_empty", sb_empty, 1);
    exu_valid = 0; issue_valid = 1; issue_rd = 3; rs1 = 3;
    repeat (3) cycle();
    #1;
    chk("sat_issue_ready", issue_ready, 0);
    chk("sat_rs1_busy", rs1_busy, 1);
    cycle();
    issue_valid = 0; lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    repeat (3) begin
      #1;
      chk("cm_rs1_busy", rs1_busy, 1);
      cycle();
    end
    lsu_valid = 0;
    #1;
    chk("cm_rs1_idle", rs1_busy, 0);
    cycle();
    issue_valid = 1; issue_rd = 7; rs2 = 7;
    cycle();
    exu_valid = 1; exu_rd = 7; exu_data = 32'h77;
    cycle();
    issue_valid = 0; exu_rd = 9; rs1 = 9;
    #1;
    chk("same_rs2_busy", rs2_busy, 1);
    cycle();
    exu_valid = 0;
    #1;
    chk("idle9_rs1_busy", rs1_busy, 0);
    chk("same_rs2_still", rs2_busy, 1);
    cycle();
    issue_valid = 1;
    for (int k = 10; k < 14; k++) begin
      issue_rd = 5'(k);
      cycle();
    end
    issue_valid = 0; lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20; flush = 1;
    #1;
    chk("fl_lsu_ready", lsu_ready, 0);
    chk("fl_sb_full", sb_empty, 0);
    cycle();
    flush = 0; exu_valid = 1; exu_rd = 21;
    #1;
    chk("fl_sb_empty", sb_empty, 1);
    chk("fl_prio_lsu", lsu_ready, 1);
    chk("fl_prio_exu", exu_ready, 0);
    cycle();
    for (int n = 0; n < 3000; n++) begin
      bit hold_e, hold_l;
      hold_e = exu_valid && !m_ge;
      hold_l = lsu_valid && !m_gl;
      rst = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 15) == 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      if (!hold_e) begin
        exu_valid = $urandom_range(0, 1) == 1;
        exu_rd = 5'($urandom_range(0, 7));
        exu_data = $urandom;
      end
      if (!hold_l) begin
        lsu_valid = $urandom_range(0, 1) == 1;
        lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = $urandom;
      end
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
